quad_encoder_mc: RTL and testbench
==================================

# quad_encoder_mc

Multi-channel quadrature encoder decoder for Sandpiper-class boards. It extends the single-channel 400 Hz rotary-encoder counter with N independent channels, input synchronisation and glitch filtering, and a runtime x1/x2/x4 resolution mode. It adds illegal-transition detection and per-channel clear. It sits between the encoder pins and the UART/seven-segment display logic, and presents signed per-channel positions plus single-cycle step pulses.

## Interface
- N_CH, 2: number of encoder channels (1..8)
- D_RES, 16: counter width per channel, two's complement
- SYSCLK_F, 12000000: sys_clk frequency in Hz
- SAMPLE_HZ, 4000: sample strobe rate; strobe period P = SYSCLK_F/SAMPLE_HZ cycles, elaboration error if P < 2
- FILT_LEN, 3: consecutive identical samples required to accept a new A/B state (1 = filter off)
- sys_clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; when low, all state holds and pulses are forced low
- mode  in  2  00 = x1, 01 = x2, 10/11 = x4
- clear  in  N_CH  per-channel counter clear, level-sensitive
- err_clr  in  1  clears all sticky error flags
- enc_a, enc_b  in  N_CH each  raw asynchronous encoder pins
- count  out  N_CH*D_RES  channel i occupies bits [i*D_RES +: D_RES], signed
- cw, ccw  out  N_CH each  one-cycle step pulses
- update  out  1  one-cycle pulse, OR of all cw|ccw
- err  out  N_CH  sticky: both A and B changed between accepted states

## Operation
- Each pin passes through a 2-flop synchroniser. A shared divider produces a one-cycle strobe every P cycles.
- On each strobe, each channel compares the synchronised {A,B} with a candidate register and a run counter:
  - If they are equal, the run counter increments, saturating at FILT_LEN.
  - Otherwise the candidate is reloaded and the run counter is set to 1.
  - When the run count reaches FILT_LEN and the candidate differs from the accepted state, the candidate becomes the accepted state and a transition {old,new} is evaluated.
- After reset, the first accepted state only primes the channel (a primed flag is set). It produces no count and no error.
- CW sequence is 00→10→11→01→00 (+1 per step). CCW is the reverse (−1 per step).
- Counting by mode:
  - x4: every legal transition counts.
  - x2: only transitions ending in 00 or 11 count.
  - x1: only 01→00 (+1) and 00→01 (−1) count.
- Illegal transition (00↔11, 01↔10): the count is unchanged, err[i] is set, and the new state is still accepted.
- Arithmetic:
  - Default: the counter wraps modulo 2^D_RES.
  - With saturation compiled in: the counter holds at 2^(D_RES−1)−1 and −2^(D_RES−1).
  - cw/ccw pulse even when the count is held by saturation.
- Priority per channel, highest first: rst_n, clear[i], step. When clear and a step coincide, count becomes 0 and no cw/ccw pulse is emitted.
- err_clr clears flags. If it coincides with a new illegal transition, err stays set.
- A mode change takes effect at the next strobe. It never alters an existing count.

## Timing
- Reset values: count = 0, cw = ccw = 0, update = 0, err = 0. Primed flags, filter state and divider are all cleared.
- Latency from a pin change to the cw/ccw/update pulse and the count update (same cycle): 2 synchroniser cycles, then up to P cycles to the strobe, then (FILT_LEN−1)·P cycles, then 1 cycle.
- cw/ccw/update are high for exactly one sys_clk cycle.
- clear is effective the cycle after assertion, independent of the strobe.
- When en is low, the divider freezes and clear is ignored. Strobe phase resumes on re-enable.
- rst_n asserted mid-filter discards the pending candidate. The channel re-primes after release.

## Configuration
- QENC_SAT_EN defined: counters saturate at signed min/max.
- QENC_SAT_EN undefined: counters wrap.
- The only compile-time switch.

## Structure
- Package quad_enc_pkg holds:
  - mode encodings QENC_X1/X2/X4;
  - named 4-bit {old,new} transition constants;
  - a step-decode function returning +1/−1/0/illegal for a given mode.
- Sub-module quad_encoder_chan implements one channel (synchroniser, filter, decode, counter, err). It is instantiated N_CH times in a generate loop. The top holds the divider and the update OR.

## Test plan
- Reset, x4, P = 4 (SYSCLK_F = 1000, SAMPLE_HZ = 250), FILT_LEN = 3; drive ch0 through one full CW cycle 00→10→11→01→00 with each state held 4 strobes → count0 = +4, four cw pulses, count1 = 0.
- Same full cycle driven CCW in x2 → count0 = −2; in x1 → count0 = −1.
- 1-strobe glitch 00→10→00 on A → no pulse, count unchanged. 00→11 held 3 strobes → err[0] = 1, count unchanged; err_clr → err[0] = 0.
- Wrap: count at 0x7FFF, one CW step → 0x8000. With QENC_SAT_EN, same stimulus → stays 0x7FFF with a cw pulse. At 0x8000 plus a CCW step, it stays 0x8000.
- clear[1] asserted in the same cycle as a ch1 step → count1 = 0, no cw/ccw[1] pulse. ch0 steps unaffected.
- rst_n asserted mid-run with pins at 11 → all outputs 0. After release, the first accepted 11 produces no count and no error. The next 11→01 gives +1.

Source files
------------

// File: rtl/quad_enc_pkg.sv
// Shared encodings and the step-decode table for the multi-channel quadrature decoder.
package quad_enc_pkg;

  localparam logic [1:0] QENC_X1 = 2'b00;
  localparam logic [1:0] QENC_X2 = 2'b01;
  localparam logic [1:0] QENC_X4 = 2'b10;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ILL} step_e;

  // {old,new} transitions; CW order is 00->10->11->01->00
  localparam logic [3:0] TR_00_10 = 4'b0010;
  localparam logic [3:0] TR_10_11 = 4'b1011;
  localparam logic [3:0] TR_11_01 = 4'b1101;
  localparam logic [3:0] TR_01_00 = 4'b0100;
  localparam logic [3:0] TR_00_01 = 4'b0001;
  localparam logic [3:0] TR_01_11 = 4'b0111;
  localparam logic [3:0] TR_11_10 = 4'b1110;
  localparam logic [3:0] TR_10_00 = 4'b1000;
  localparam logic [3:0] TR_00_11 = 4'b0011;
  localparam logic [3:0] TR_11_00 = 4'b1100;
  localparam logic [3:0] TR_01_10 = 4'b0110;
  localparam logic [3:0] TR_10_01 = 4'b1001;

  function automatic step_e step_decode(input logic [1:0] mode, input logic [3:0] tr);
    step_e s;
    logic  x2, x4;
    s  = STEP_NONE;
    x2 = (mode == QENC_X2);
    x4 = (mode != QENC_X1) && !x2;
    case (tr)
      TR_01_00:                      s = STEP_UP;
      TR_00_01:                      if (!x2) s = STEP_DN;
      TR_10_11:                      if (!x4 && !x2) s = STEP_NONE; else s = STEP_UP;
      TR_10_00, TR_01_11:            if (x4 || x2) s = STEP_DN;
      TR_00_10, TR_11_01:            if (x4) s = STEP_UP;
      TR_11_10:                      if (x4) s = STEP_DN;
      TR_00_11, TR_11_00,
      TR_01_10, TR_10_01:            s = STEP_ILL;
      default:                       s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_encoder_chan.sv
// One encoder channel: pin synchroniser, run-length filter, transition decode, counter, sticky error.
// Counter saturates at signed min/max when QENC_SAT_EN is defined, wraps otherwise.
module quad_encoder_chan
  import quad_enc_pkg::*;
#(
  parameter int D_RES    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    strobe,
  input  logic [1:0]              mode,
  input  logic                    clear,
  input  logic                    err_clr,
  input  logic                    enc_a,
  input  logic                    enc_b,
  output logic signed [D_RES-1:0] count,
  output logic                    cw,
  output logic                    ccw,
  output logic                    err
);

  localparam int             RW      = $clog2(FILT_LEN + 1);
  localparam logic [RW-1:0]  RUN_MAX = RW'(FILT_LEN);

  logic [1:0]              r_sync_a, r_sync_b;
  logic [1:0]              r_cand, r_acc;
  logic [RW-1:0]           r_run;
  logic                    r_primed;
  logic signed [D_RES-1:0] r_cnt;
  logic                    r_cw, r_ccw, r_err;

  logic [1:0]              w_ab, w_cand_nxt;
  logic [RW-1:0]           w_run_nxt;
  logic                    w_accept;
  step_e                   w_step;
  logic signed [D_RES-1:0] w_cnt_up, w_cnt_dn;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[0], enc_a};
      r_sync_b <= {r_sync_b[0], enc_b};
    end
  end

  assign w_ab = {r_sync_a[1], r_sync_b[1]};

  always_comb begin
    w_cand_nxt = w_ab;
    w_run_nxt  = RW'(1);
    if (w_ab == r_cand) begin
      w_cand_nxt = r_cand;
      w_run_nxt  = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
    end
  end

  // The first accepted state after reset only primes; it has no predecessor to decode against.
  assign w_accept = strobe && (w_run_nxt == RUN_MAX) && (!r_primed || (w_cand_nxt != r_acc));
  assign w_step   = (w_accept && r_primed) ? step_decode(mode, {r_acc, w_cand_nxt}) : STEP_NONE;

`ifdef QENC_SAT_EN
  localparam logic signed [D_RES-1:0] CNT_MAX = {1'b0, {(D_RES-1){1'b1}}};
  localparam logic signed [D_RES-1:0] CNT_MIN = {1'b1, {(D_RES-1){1'b0}}};
  assign w_cnt_up = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_dn = (r_cnt == CNT_MIN) ? r_cnt : r_cnt - 1'b1;
`else
  assign w_cnt_up = r_cnt + 1'b1;
  assign w_cnt_dn = r_cnt - 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= '0;
      r_run    <= '0;
      r_acc    <= '0;
      r_primed <= 1'b0;
      r_cnt    <= '0;
      r_cw     <= 1'b0;
      r_ccw    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cw  <= 1'b0;
      r_ccw <= 1'b0;
      if (strobe) begin
        r_cand <= w_cand_nxt;
        r_run  <= w_run_nxt;
      end
      if (w_accept) begin
        r_acc    <= w_cand_nxt;
        r_primed <= 1'b1;
      end
      if (en && clear) begin
        r_cnt <= '0;
      end else if (w_step == STEP_UP) begin
        r_cnt <= w_cnt_up;
        r_cw  <= 1'b1;
      end else if (w_step == STEP_DN) begin
        r_cnt <= w_cnt_dn;
        r_ccw <= 1'b1;
      end
      // a fresh illegal transition beats a simultaneous err_clr
      if (en && err_clr) r_err <= 1'b0;
      if (w_step == STEP_ILL) r_err <= 1'b1;
    end
  end

  assign count = r_cnt;
  assign cw    = r_cw & en;
  assign ccw   = r_ccw & en;
  assign err   = r_err;

endmodule

// File: rtl/quad_encoder_mc.sv
// N-channel quadrature decoder top: shared sample-strobe divider, channel array, update OR.
// Define QENC_SAT_EN to make channel counters saturate instead of wrapping.
module quad_encoder_mc
  import quad_enc_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int D_RES     = 16,
  parameter int SYSCLK_F  = 12000000,
  parameter int SAMPLE_HZ = 4000,
  parameter int FILT_LEN  = 3
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [N_CH-1:0]         clear,
  input  logic                    err_clr,
  input  logic [N_CH-1:0]         enc_a,
  input  logic [N_CH-1:0]         enc_b,
  output logic [N_CH*D_RES-1:0]   count,
  output logic [N_CH-1:0]         cw,
  output logic [N_CH-1:0]         ccw,
  output logic                    update,
  output logic [N_CH-1:0]         err
);

  localparam int P  = SYSCLK_F / SAMPLE_HZ;
  localparam int DW = (P < 2) ? 1 : $clog2(P);
  localparam logic [DW-1:0] DIV_LAST = DW'(P - 1);

  if (P < 2) begin : g_bad_p
    $error("quad_encoder_mc: SYSCLK_F/SAMPLE_HZ must be at least 2");
  end

  logic [DW-1:0] r_div;
  logic          w_strobe;

  // strobe is gated by en so a disabled block sees no sample and the phase resumes intact
  assign w_strobe = en && (r_div == DIV_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)  r_div <= '0;
    else if (en) r_div <= w_strobe ? '0 : r_div + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    quad_encoder_chan #(
      .D_RES    (D_RES),
      .FILT_LEN (FILT_LEN)
    ) u_chan (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .en      (en),
      .strobe  (w_strobe),
      .mode    (mode),
      .clear   (clear[i]),
      .err_clr (err_clr),
      .enc_a   (enc_a[i]),
      .enc_b   (enc_b[i]),
      .count   (count[i*D_RES +: D_RES]),
      .cw      (cw[i]),
      .ccw     (ccw[i]),
      .err     (err[i])
    );
  end

  assign update = |{cw, ccw};

endmodule

// File: tb/tb_quad_encoder_mc.sv
// Bench for quad_encoder_mc: 2-channel 16-bit instance plus a 1-channel 4-bit instance for wrap/saturation.
module tb_quad_encoder_mc;

  localparam int PER = 4;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1, err_clr = 1'b0;
  logic [1:0]  mode = 2'b10;
  logic [1:0]  clear = '0, enc_a = '0, enc_b = '0;
  logic [31:0] count;
  logic [1:0]  cw, ccw, err;
  logic        update;
  logic        clear_w = 1'b0, a_w = 1'b0, b_w = 1'b0;
  logic [3:0]  count_w;
  logic        cw_w, ccw_w, err_w, update_w;

  always #5 clk = ~clk;

  quad_encoder_mc #(.N_CH(2), .D_RES(16), .SYSCLK_F(1000), .SAMPLE_HZ(250), .FILT_LEN(3)) u_dut (
    .sys_clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .clear(clear), .err_clr(err_clr),
    .enc_a(enc_a), .enc_b(enc_b), .count(count), .cw(cw), .ccw(ccw), .update(update), .err(err));

  quad_encoder_mc #(.N_CH(1), .D_RES(4), .SYSCLK_F(1000), .SAMPLE_HZ(250), .FILT_LEN(3)) u_dutw (
    .sys_clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .clear(clear_w), .err_clr(err_clr),
    .enc_a(a_w), .enc_b(b_w), .count(count_w), .cw(cw_w), .ccw(ccw_w), .update(update_w), .err(err_w));

  // reference model: position on the 4-state Gray wheel, one entry per channel (ch2 = 4-bit instance)
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] m_acc [3];
  logic [1:0] pin_s [3];
  bit         m_primed [3];
  bit         m_err [3];
  int         m_cnt [3];
  int         m_cw [3];
  int         m_ccw [3];
  logic [1:0] m_mode;
  int         n_checks = 0, n_errors = 0;

  int         cnt_cw [3] = '{0, 0, 0};
  int         cnt_ccw [3] = '{0, 0, 0};
  int         pw_bad = 0, upd_bad = 0;
  logic [2:0] pcw, pccw;
  logic [2:0] prv_cw = '0, prv_ccw = '0;

  assign pcw  = {cw_w, cw};
  assign pccw = {ccw_w, ccw};

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (pcw[c])  cnt_cw[c]  <= cnt_cw[c] + 1;
      if (pccw[c]) cnt_ccw[c] <= cnt_ccw[c] + 1;
    end
    if (((pcw & prv_cw) != 0) || ((pccw & prv_ccw) != 0)) pw_bad <= pw_bad + 1;
    if ((update !== |{cw, ccw}) || (update_w !== (cw_w | ccw_w))) upd_bad <= upd_bad + 1;
    prv_cw  <= pcw;
    prv_ccw <= pccw;
  end

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int dut_cnt(input int c);
    logic [15:0] v;
    if (c == 2) return int'($signed(count_w));
    v = count[c*16 +: 16];
    return int'($signed(v));
  endfunction

  function automatic logic dut_err(input int c);
    if (c == 2) return err_w;
    return err[c];
  endfunction

  task automatic m_accept(input int c, input logic [1:0] s, input bit clr);
    int d, lim;
    bit cnt_it;
    if (!m_primed[c]) begin
      m_primed[c] = 1'b1;
      m_acc[c]    = s;
      return;
    end
    if (s == m_acc[c]) return;
    d = (gidx(s) - gidx(m_acc[c]) + 4) % 4;
    if (d == 2) m_err[c] = 1'b1;
    else begin
      case (m_mode)
        2'b00:   cnt_it = (m_acc[c] == 2'b01 && s == 2'b00) || (m_acc[c] == 2'b00 && s == 2'b01);
        2'b01:   cnt_it = (s == 2'b00) || (s == 2'b11);
        default: cnt_it = 1'b1;
      endcase
      if (cnt_it && !clr) begin
        lim = (c == 2) ? 8 : 32768;
        m_cnt[c] += (d == 1) ? 1 : -1;
`ifdef QENC_SAT_EN
        if (m_cnt[c] > lim - 1) m_cnt[c] = lim - 1;
        if (m_cnt[c] < -lim)    m_cnt[c] = -lim;
`else
        if (m_cnt[c] > lim - 1) m_cnt[c] -= 2 * lim;
        if (m_cnt[c] < -lim)    m_cnt[c] += 2 * lim;
`endif
        if (d == 1) m_cw[c]++;
        else        m_ccw[c]++;
      end
    end
    m_acc[c] = s;
  endtask

  task automatic set_pins(input int c, input logic [1:0] s);
    pin_s[c] = s;
    if (c == 2) begin a_w = s[1]; b_w = s[0]; end
    else begin enc_a[c] = s[1]; enc_b[c] = s[0]; end
  endtask

  task automatic hold(input int strobes);
    repeat (strobes * PER) @(negedge clk);
  endtask

  task automatic settle(input bit [2:0] clr_mask);
    for (int c = 0; c < 3; c++) m_accept(c, pin_s[c], clr_mask[c]);
  endtask

  task automatic step_ch(input int c, input int dir);
    set_pins(c, seq[(gidx(pin_s[c]) + dir + 4) % 4]);
    hold(5);
    settle(3'b000);
  endtask

  task automatic set_mode(input logic [1:0] md);
    m_mode = md;
    mode   = md;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (count !== 32'd0 || count_w !== 4'd0) begin
      n_errors++; $display("FAIL reset_count got %h/%h exp 0", count, count_w);
    end
    n_checks++;
    if ({cw, ccw, update, err, cw_w, ccw_w, update_w, err_w} !== '0) begin
      n_errors++; $display("FAIL reset_flags got %b exp 0", {cw, ccw, update, err, cw_w, ccw_w, update_w, err_w});
    end
    rst_n = 1'b1;
    hold(5);
    settle(3'b000);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (dut_cnt(c) !== 0 || cnt_cw[c] !== 0 || cnt_ccw[c] !== 0 || dut_err(c) !== 1'b0) begin
        n_errors++; $display("FAIL prime ch%0d cnt %0d cw %0d ccw %0d err %b exp all 0", c, dut_cnt(c), cnt_cw[c], cnt_ccw[c], dut_err(c));
      end
    end
  endtask

  task automatic test_x4_cw;
    set_mode(2'b10);
    for (int k = 0; k < 4; k++) step_ch(0, 1);
    n_checks++;
    if (dut_cnt(0) !== m_cnt[0]) begin n_errors++; $display("FAIL x4_count0 got %0d exp %0d", dut_cnt(0), m_cnt[0]); end
    n_checks++;
    if (cnt_cw[0] !== m_cw[0]) begin n_errors++; $display("FAIL x4_cw0 got %0d exp %0d", cnt_cw[0], m_cw[0]); end
    n_checks++;
    if (dut_cnt(1) !== m_cnt[1]) begin n_errors++; $display("FAIL x4_count1 got %0d exp %0d", dut_cnt(1), m_cnt[1]); end
  endtask

  task automatic test_modes_ccw;
    int base;
    set_mode(2'b01);
    base = m_cnt[0];
    for (int k = 0; k < 4; k++) step_ch(0, -1);
    n_checks++;
    if (dut_cnt(0) !== m_cnt[0] || m_cnt[0] - base !== -2) begin
      n_errors++; $display("FAIL x2_ccw got %0d exp %0d", dut_cnt(0), base - 2);
    end
    set_mode(2'b00);
    base = m_cnt[0];
    for (int k = 0; k < 4; k++) step_ch(0, -1);
    n_checks++;
    if (dut_cnt(0) !== m_cnt[0] || m_cnt[0] - base !== -1) begin
      n_errors++; $display("FAIL x1_ccw got %0d exp %0d", dut_cnt(0), base - 1);
    end
    n_checks++;
    if (cnt_ccw[0] !== m_ccw[0]) begin n_errors++; $display("FAIL mode_ccw_pulses got %0d exp %0d", cnt_ccw[0], m_ccw[0]); end
  endtask

  task automatic test_glitch_err;
    int c0, p0;
    set_mode(2'b10);
    c0 = dut_cnt(0);
    p0 = cnt_cw[0] + cnt_ccw[0];
    set_pins(0, 2'b10);
    hold(1);
    set_pins(0, 2'b00);
    hold(5);
    settle(3'b000);
    n_checks++;
    if (dut_cnt(0) !== c0 || cnt_cw[0] + cnt_ccw[0] !== p0) begin
      n_errors++; $display("FAIL glitch cnt %0d pulses %0d exp %0d/%0d", dut_cnt(0), cnt_cw[0] + cnt_ccw[0], c0, p0);
    end
    set_pins(0, 2'b11);
    hold(5);
    settle(3'b000);
    n_checks++;
    if (err[0] !== 1'b1 || m_err[0] !== 1'b1 || dut_cnt(0) !== m_cnt[0]) begin
      n_errors++; $display("FAIL illegal err %b cnt %0d exp 1/%0d", err[0], dut_cnt(0), m_cnt[0]);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    for (int c = 0; c < 3; c++) m_err[c] = 1'b0;
    n_checks++;
    if (err !== 2'b00) begin n_errors++; $display("FAIL err_clr got %b exp 00", err); end
    step_ch(0, 1);
    step_ch(0, 1);
  endtask

  task automatic test_wrap;
    int p;
    set_mode(2'b10);
    for (int k = 0; k < 20 && m_cnt[2] != 7; k++) step_ch(2, 1);
    p = cnt_cw[2];
    step_ch(2, 1);
    n_checks++;
    if (dut_cnt(2) !== m_cnt[2]) begin n_errors++; $display("FAIL max_step got %0d exp %0d", dut_cnt(2), m_cnt[2]); end
    n_checks++;
    if (cnt_cw[2] - p !== 1) begin n_errors++; $display("FAIL max_cw_pulse got %0d exp 1", cnt_cw[2] - p); end
    for (int k = 0; k < 20 && m_cnt[2] != -8; k++) step_ch(2, -1);
    p = cnt_ccw[2];
    step_ch(2, -1);
    n_checks++;
    if (dut_cnt(2) !== m_cnt[2]) begin n_errors++; $display("FAIL min_step got %0d exp %0d", dut_cnt(2), m_cnt[2]); end
    n_checks++;
    if (cnt_ccw[2] - p !== 1) begin n_errors++; $display("FAIL min_ccw_pulse got %0d exp 1", cnt_ccw[2] - p); end
  endtask

  task automatic test_clear;
    set_mode(2'b10);
    step_ch(1, 1);
    step_ch(1, 1);
    clear = 2'b10;
    m_cnt[1] = 0;
    @(negedge clk);
    n_checks++;
    if (dut_cnt(1) !== 0) begin n_errors++; $display("FAIL clear_next_cycle got %0d exp 0", dut_cnt(1)); end
    set_pins(0, seq[(gidx(pin_s[0]) + 1) % 4]);
    set_pins(1, seq[(gidx(pin_s[1]) + 1) % 4]);
    hold(5);
    settle(3'b010);
    clear = 2'b00;
    @(negedge clk);
    n_checks++;
    if (dut_cnt(1) !== 0 || cnt_cw[1] !== m_cw[1]) begin
      n_errors++; $display("FAIL clear_step cnt1 %0d cw1 %0d exp 0/%0d", dut_cnt(1), cnt_cw[1], m_cw[1]);
    end
    n_checks++;
    if (dut_cnt(0) !== m_cnt[0] || cnt_cw[0] !== m_cw[0]) begin
      n_errors++; $display("FAIL clear_ch0 cnt0 %0d cw0 %0d exp %0d/%0d", dut_cnt(0), cnt_cw[0], m_cnt[0], m_cw[0]);
    end
  endtask

  task automatic test_enable;
    int c0;
    set_mode(2'b10);
    c0 = m_cnt[0];
    en = 1'b0;
    set_pins(0, seq[(gidx(pin_s[0]) + 1) % 4]);
    clear = 2'b01;
    hold(10);
    n_checks++;
    if (dut_cnt(0) !== c0 || cnt_cw[0] !== m_cw[0]) begin
      n_errors++; $display("FAIL en_low cnt %0d cw %0d exp %0d/%0d", dut_cnt(0), cnt_cw[0], c0, m_cw[0]);
    end
    clear = 2'b00;
    @(negedge clk);
    en = 1'b1;
    hold(5);
    settle(3'b000);
    n_checks++;
    if (dut_cnt(0) !== m_cnt[0]) begin n_errors++; $display("FAIL en_resume got %0d exp %0d", dut_cnt(0), m_cnt[0]); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      set_mode(2'($urandom_range(0, 3)));
      for (int c = 0; c < 3; c++) if ($urandom_range(0, 1) == 1) set_pins(c, 2'($urandom_range(0, 3)));
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        err_clr = 1'b1;
        for (int c = 0; c < 3; c++) m_err[c] = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
      end
      hold(5);
      settle(3'b000);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (dut_cnt(c) !== m_cnt[c] || dut_err(c) !== m_err[c]) begin
          n_errors++; $display("FAIL rand it%0d ch%0d cnt %0d err %b exp %0d/%b", it, c, dut_cnt(c), dut_err(c), m_cnt[c], m_err[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int p;
    set_mode(2'b10);
    for (int k = 0; k < 4 && pin_s[0] != 2'b11; k++) begin
      if (gidx(pin_s[0]) == 0 || gidx(pin_s[0]) == 1) step_ch(0, 1);
      else step_ch(0, -1);
    end
    set_pins(1, seq[(gidx(pin_s[1]) + 1) % 4]);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 32'd0 || count_w !== 4'd0 || {cw, ccw, update, err, cw_w, ccw_w, update_w, err_w} !== '0) begin
      n_errors++; $display("FAIL mid_reset count %h/%h flags %b exp 0", count, count_w, {cw, ccw, update, err, cw_w, ccw_w, update_w, err_w});
    end
    for (int c = 0; c < 3; c++) begin m_primed[c] = 1'b0; m_cnt[c] = 0; m_err[c] = 1'b0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p = cnt_cw[0] + cnt_ccw[0];
    hold(5);
    settle(3'b000);
    n_checks++;
    if (dut_cnt(0) !== 0 || err[0] !== 1'b0 || cnt_cw[0] + cnt_ccw[0] !== p) begin
      n_errors++; $display("FAIL reprime cnt %0d err %b pulses %0d exp 0/0/%0d", dut_cnt(0), err[0], cnt_cw[0] + cnt_ccw[0], p);
    end
    step_ch(0, 1);
    n_checks++;
    if (dut_cnt(0) !== m_cnt[0] || m_cnt[0] !== 1) begin
      n_errors++; $display("FAIL after_reprime got %0d exp 1", dut_cnt(0));
    end
  endtask

  task automatic test_pulses;
    n_checks++;
    if (pw_bad !== 0) begin n_errors++; $display("FAIL pulse_width got %0d long pulses exp 0", pw_bad); end
    n_checks++;
    if (upd_bad !== 0) begin n_errors++; $display("FAIL update_or got %0d bad cycles exp 0", upd_bad); end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (cnt_cw[c] !== m_cw[c] || cnt_ccw[c] !== m_ccw[c]) begin
        n_errors++; $display("FAIL pulse_total ch%0d cw %0d ccw %0d exp %0d/%0d", c, cnt_cw[c], cnt_ccw[c], m_cw[c], m_ccw[c]);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_acc[c] = 2'b00; pin_s[c] = 2'b00; m_primed[c] = 1'b0; m_err[c] = 1'b0;
      m_cnt[c] = 0; m_cw[c] = 0; m_ccw[c] = 0;
    end
    m_mode = 2'b10;
    test_reset;
    test_x4_cw;
    test_modes_ccw;
    test_glitch_err;
    test_wrap;
    test_clear;
    test_enable;
    test_random;
    test_reset_mid;
    hold(2);
    test_pulses;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
